// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
//
// Purpose:
//   Drives the 4-bit pattern select of the VGA test pattern generator.
//   Pattern changes come from next/prev user pulses or from an optional
//   auto-cycle timer counted in frames. A change is only ever applied on a
//   frame boundary (i_frame_strobe), so a pattern never switches mid-frame.
//
// Optional feature:
//   PATTERN_SEQUENCER_BLANK_EN - when defined, every change passes through
//   BLANK_FRAMES whole frames of pattern 0 before the new pattern appears.
//   When undefined, the change is applied directly at the servicing strobe
//   and BLANK_FRAMES is ignored.
//
// Ports:
//   i_clk            in   1  pixel clock
//   i_reset          in   1  synchronous, active-high reset
//   i_frame_strobe   in   1  one-cycle pulse at frame start
//   i_next           in   1  one-cycle pulse: request next pattern
//   i_prev           in   1  one-cycle pulse: request previous pattern
//   i_auto_toggle    in   1  one-cycle pulse: toggle auto-cycle mode
//   o_pattern        out  4  registered pattern select (0 = black)
//   o_auto           out  1  registered auto-mode flag
//   o_change_strobe  out  1  pulses with each new non-zero o_pattern
// -----------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS  = 9,   // 3..16, index 0 is black
    parameter int unsigned FIRST_PATTERN = 1,   // lowest selectable, reset value
    parameter int unsigned AUTO_FRAMES   = 120, // frames per pattern in auto mode
    parameter int unsigned BLANK_FRAMES  = 2    // black frames between patterns
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_strobe,
    input  logic       i_next,
    input  logic       i_prev,
    input  logic       i_auto_toggle,
    output logic [3:0] o_pattern,
    output logic       o_auto,
    output logic       o_change_strobe
);

    localparam int unsigned        FW        = $clog2(AUTO_FRAMES + 1);
    localparam logic [FW-1:0]      AUTO_LAST = FW'(AUTO_FRAMES - 1);
    localparam logic [3:0]         FIRST     = 4'(FIRST_PATTERN);
    localparam logic [3:0]         LAST      = 4'(NUM_PATTERNS - 1);

    typedef enum logic {
        DIR_NEXT,
        DIR_PREV
    } dir_e;

    logic          pend_valid;
    dir_e          pend_dir;
    logic [FW-1:0] frame_cnt;

`ifdef PATTERN_SEQUENCER_BLANK_EN
    localparam int unsigned   BW         = $clog2(BLANK_FRAMES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);

    typedef enum logic {
        SHOW,
        BLANK
    } state_e;

    state_e        state;
    logic [BW-1:0] blank_cnt;
    logic [3:0]    target_q;   // pattern to show once the blank interval ends
    logic          in_show;

    assign in_show = (state == SHOW);
`else
    logic          in_show;

    // Without blanking the sequencer is permanently in its SHOW behaviour.
    assign in_show = 1'b1;
`endif

    // Exactly one of next/prev is a request; both at once is ignored.
    logic req_one;
    assign req_one = i_next ^ i_prev;

    // Auto expiry preempts any pending manual request on the same strobe.
    logic auto_expire;
    assign auto_expire = o_auto && in_show && i_frame_strobe && (frame_cnt == AUTO_LAST);

    logic service;
    assign service = in_show && i_frame_strobe && (auto_expire || pend_valid);

    dir_e svc_dir;
    assign svc_dir = auto_expire ? DIR_NEXT : pend_dir;

    // Wrap checks compare against the limits before adding, so the 4-bit
    // increment can never overflow even with NUM_PATTERNS = 16.
    logic [3:0] target;
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        target = o_pattern;
        if (svc_dir == DIR_NEXT) begin
            target = (o_pattern >= LAST) ? FIRST : o_pattern + 4'd1;
        end else begin
            target = (o_pattern == FIRST) ? LAST : o_pattern - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pattern       <= FIRST;
            o_auto          <= 1'b0;
            o_change_strobe <= 1'b0;
            pend_valid      <= 1'b0;
            pend_dir        <= DIR_NEXT;
            frame_cnt       <= '0;
`ifdef PATTERN_SEQUENCER_BLANK_EN
            state           <= SHOW;
            blank_cnt       <= '0;
            target_q        <= FIRST;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            o_change_strobe <= 1'b0;

            // Frame counter: cleared by the toggle, frozen while blanking,
            // restarted whenever a change is serviced in auto mode.
            if (i_auto_toggle) begin
                o_auto    <= ~o_auto;
                frame_cnt <= '0;
            end else if (o_auto && in_show && i_frame_strobe) begin
                frame_cnt <= service ? '0 : frame_cnt + FW'(1);
            end

            // A request arriving in the servicing cycle is kept for the next
            // strobe, so it overrides the clear caused by servicing.
            if (in_show && req_one) begin
                pend_valid <= 1'b1;
                pend_dir   <= i_next ? DIR_NEXT : DIR_PREV;
            end else if (service) begin
                pend_valid <= 1'b0;
            end

`ifdef PATTERN_SEQUENCER_BLANK_EN
            case (state)
                SHOW: begin
                    if (service) begin
                        state     <= BLANK;
                        target_q  <= target;
                        o_pattern <= 4'd0;
                        blank_cnt <= '0;
                    end
                end
                BLANK: begin
                    if (i_frame_strobe) begin
                        if (blank_cnt == BLANK_LAST) begin
                            state           <= SHOW;
                            o_pattern       <= target_q;
                            o_change_strobe <= 1'b1;
                        end else begin
                            blank_cnt <= blank_cnt + BW'(1);
                        end
                    end
                end
                default: state <= SHOW;
            endcase
`else
            if (service) begin
                o_pattern       <= target;
                o_change_strobe <= 1'b1;
            end
`endif
        end
    end

endmodule
